// File: rtl/conv_pkg.sv
// Shared types and fixed-point helpers for the conv_pfm_stream convolution engine.
// Holds the frame FSM encoding, the saturation function and width helpers.
package conv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam int SAT_W    = 64;  // working width handed to sat_w()
   localparam int N_STAGES = 5;   // S0 fetch .. S4 output register

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Clamp a signed value into the signed range of a dw-bit word.
   function automatic logic signed [SAT_W-1:0] sat_w(input logic signed [SAT_W-1:0] x,
                                                     input int dw);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One kernel's datapath behind the shared window register: S1 multiply, S2 rescale,
// S3 sum, S4 saturate (+ ReLU when CONV_PFM_RELU_EN is defined) into the output register.
module conv_mac_lane
   import conv_pkg::*;
#(
   parameter int K_SIZE = 3,
   parameter int DW     = 16,
   parameter int FRAC   = 15
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_en,
   input  logic [DW*K_SIZE*K_SIZE-1:0] i_win,
   input  logic [DW*K_SIZE*K_SIZE-1:0] i_ker,
   output logic [DW-1:0]               o_data
);

   localparam int NT = K_SIZE * K_SIZE;
   localparam int SW = DW + clog2(NT) + 1;

   logic signed [2*DW-1:0] r_prod [NT];
   logic signed [DW-1:0]   r_shf  [NT];
   logic signed [SW-1:0]   r_sum;
   logic        [DW-1:0]   r_out;
   logic signed [SW-1:0]   w_sum;
   logic signed [DW-1:0]   w_sat;

   // NOTE: every variable driven here gets a default before any conditional use, so no latch.
   always_comb begin
      w_sum = '0;
      for (int i = 0; i < NT; i++) begin
         w_sum = w_sum + {{(SW-DW){r_shf[i][DW-1]}}, r_shf[i]};
      end
   end

   always_comb begin
      w_sat = DW'(sat_w(SAT_W'(r_sum), DW));
`ifdef CONV_PFM_RELU_EN
      if (w_sat[DW-1]) w_sat = '0;
`endif
   end

   // NOTE: sequential state uses non-blocking assignment so all stages see pre-edge values.
   // NOTE: pipeline data registers are reset too, so out_data reads zero after rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NT; i++) begin
            r_prod[i] <= '0;
            r_shf[i]  <= '0;
         end
         r_sum <= '0;
         r_out <= '0;
      end else if (i_en) begin
         for (int i = 0; i < NT; i++) begin
            r_prod[i] <= $signed(i_win[DW*i +: DW]) * $signed(i_ker[DW*i +: DW]);
            r_shf[i]  <= DW'(r_prod[i] >>> FRAC);
         end
         r_sum <= w_sum;
         r_out <= w_sat;
      end
   end

   assign o_data = r_out;

endmodule

// File: rtl/conv_pfm_stream.sv
// Multi-kernel streaming 2-D convolution: FSM, window addressing, valid chain and beat index.
// Optional fused ReLU in the lanes is enabled by defining CONV_PFM_RELU_EN.
module conv_pfm_stream
   import conv_pkg::*;
#(
   parameter  int IP_SIZE = 6,
   parameter  int K_SIZE  = 3,
   parameter  int N_KER   = 3,
   parameter  int DW      = 16,
   parameter  int FRAC    = 15,
   parameter  int STRIDE  = 1,
   localparam int OP_SIZE = (IP_SIZE - K_SIZE) / STRIDE + 1,
   localparam int IDX_W   = (OP_SIZE * OP_SIZE > 1) ? clog2(OP_SIZE * OP_SIZE) : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [DW*IP_SIZE*IP_SIZE-1:0]     ipf,
   input  logic [N_KER*DW*K_SIZE*K_SIZE-1:0] kf,
   output logic                              busy,
   output logic                              done,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [N_KER*DW-1:0]               out_data,
   output logic [IDX_W-1:0]                  out_idx
);

   localparam int NT       = K_SIZE * K_SIZE;
   localparam int RC_W     = (OP_SIZE > 1) ? clog2(OP_SIZE) : 1;
   localparam int LAST_IDX = OP_SIZE * OP_SIZE - 1;

   state_t              r_state, w_state_nx;
   logic [RC_W-1:0]     r_row, r_col;
   logic [IDX_W-1:0]    r_idx;
   logic [N_STAGES-1:0] r_vld;
   logic [DW*NT-1:0]    r_win, w_win;
   logic                w_en, w_issue, w_last_col, w_last_win, w_xfer, w_last_beat;
   logic [DW-1:0]       w_lane [N_KER];

   // A presented beat that is not taken freezes every stage, FSM and counters included.
   assign w_en        = !(r_vld[N_STAGES-1] && !out_ready);
   assign w_issue     = (r_state == ST_RUN) && w_en;
   assign w_last_col  = (r_col == RC_W'(OP_SIZE - 1));
   assign w_last_win  = w_last_col && (r_row == RC_W'(OP_SIZE - 1));
   assign w_xfer      = r_vld[N_STAGES-1] && out_ready;
   assign w_last_beat = w_xfer && (r_idx == IDX_W'(LAST_IDX));

   always_comb begin : fetch
      int base;
      base  = 0;
      w_win = '0;
      for (int kr = 0; kr < K_SIZE; kr++) begin
         for (int kc = 0; kc < K_SIZE; kc++) begin
            base = DW * ((int'(r_row) * STRIDE + kr) * IP_SIZE + int'(r_col) * STRIDE + kc);
            w_win[DW*(kr*K_SIZE+kc) +: DW] = ipf[base +: DW];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      busy       = 1'b0;
      done       = 1'b0;
      case (r_state)
         ST_IDLE:  if (start) w_state_nx = ST_RUN;
         ST_RUN: begin
            busy = 1'b1;
            if (w_issue && w_last_win) w_state_nx = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (w_last_beat) w_state_nx = ST_DONE;
         end
         ST_DONE: begin
            done       = 1'b1;
            w_state_nx = ST_IDLE;
         end
         default:  w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row <= '0;
         r_col <= '0;
         r_win <= '0;
         r_vld <= '0;
      end else if (w_en) begin
         r_vld <= {r_vld[N_STAGES-2:0], w_issue};
         if (w_issue) begin
            r_win <= w_win;
            if (w_last_col) begin
               r_col <= '0;
               r_row <= w_last_win ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_idx <= '0;
      else if (w_xfer) r_idx <= w_last_beat ? '0 : r_idx + 1'b1;
   end

   for (genvar n = 0; n < N_KER; n++) begin : g_lane
      conv_mac_lane #(
         .K_SIZE (K_SIZE),
         .DW     (DW),
         .FRAC   (FRAC)
      ) u_lane (
         .clk    (clk),
         .rst    (rst),
         .i_en   (w_en),
         .i_win  (r_win),
         .i_ker  (kf[DW*NT*n +: DW*NT]),
         .o_data (w_lane[n])
      );
      assign out_data[DW*n +: DW] = w_lane[n];
   end

   assign out_valid = r_vld[N_STAGES-1];
   assign out_idx   = r_idx;

endmodule
